cmp_pipe: RTL and testbench
===========================

CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 Parameter WIDTH, default 3: operand width in bits, legal range 2..32.
REQ-002 Parameter COUNT_W, default 8: width of the true-result counter.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the operand/function beat is valid.
REQ-006 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-007 Port a, input, WIDTH: operand A, two's complement.
REQ-008 Port b, input, WIDTH: operand B, two's complement.
REQ-009 Port cmp_fn, input, 2: 00 LTU, 01 EQ, 10 LT, 11 LE.
REQ-010 Port out_valid, output, 1: the result beat is valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result beat.
REQ-012 Port result, output, WIDTH: compare bit in bit 0, zero-extended.
REQ-013 Port flags, output, 4: {z,v,n,c} of the subtraction for the output beat.
REQ-014 Port cnt_clr, input, 1: synchronous clear of true_count.
REQ-015 Port true_count, output, COUNT_W: number of delivered beats with result bit 0 = 1.

Function
REQ-016 Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
REQ-017 Two register stages S1 and S2; global advance en = ~S2.valid | out_ready.
REQ-018 in_ready = en, combinational; no combinational path from a/b to outputs.
REQ-019 S1 on en: capture in_valid (when deasserted, the valid bit clears), s = a + ~b + 1 (WIDTH bits), carry-out c, a/b sign bits, cmp_fn.
REQ-020 Flags: z = (s==0); n = s[WIDTH-1]; c = carry-out; v = (a_msb & ~b_msb & ~s_msb) | (~a_msb & b_msb & s_msb).
REQ-021 S2 on en: capture S1.valid, flags and compare bit: LTU = ~c; EQ = z; LT = n^v; LE = z|(n^v).
REQ-022 Latency: 2 cycles from the input transfer to out_valid when out_ready is held high; throughput 1 beat per cycle.
REQ-023 Backpressure: while out_valid=1 and out_ready=0, S1, S2, result and flags hold; in_ready=0.
REQ-024 Back-to-back beats are delivered in order, with no loss and no duplication.
REQ-025 result and flags are don't-care while out_valid=0; the bench does not check them then.
REQ-026 true_count increments on an output transfer with result[0]=1; it saturates at all-ones and does not wrap.
REQ-027 cnt_clr=1 forces true_count to 0 next cycle; clear wins over a simultaneous increment.
REQ-028 The counter does not affect the handshake; cnt_clr is legal in any cycle.

Reset
REQ-029 While rst=1 (asynchronous): S1.valid=0, S2.valid=0, out_valid=0, result=0, flags=0, true_count=0; in_ready is 1 one cycle after rst deasserts.
REQ-030 Reset mid-operation discards in-flight beats; no beat emerges after release without a new input transfer.

Verification (WIDTH=3, out_ready=1 unless stated)
REQ-031 a=1, b=2, EQ -> 2 cycles later: result=000, flags z=0 v=0 n=1 c=0.
REQ-032 Test 3-2 and 2-3 with the signed-compare functions:
- a=3, b=2, LE -> result=000.
- a=2, b=3, LT -> result=001, n=1.
REQ-033 Test a=7, b=1 under both signed and unsigned compares:
- LT -> result=001.
- Same operands, LTU -> result=000, c=1.
REQ-034 a=4, b=1, LT -> s=011, v=1 n=0, result=001 (overflow case).
REQ-035 Backpressure: 4 beats issued with out_ready=0 for 3 cycles -> in_ready falls; all 4 results arrive in order; true_count counts only the delivered 1s.
REQ-036 Counter edges:
- Preload true_count at all-ones -> further true results hold it at all-ones.
- cnt_clr together with a true delivery -> 0.
- rst mid-stream -> out_valid=0 immediately and the pipeline empty.

Source files
------------

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator: subtract in S1, select compare result in S2,
// with a saturating counter of delivered true results.
module cmp_pipe #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         cmp_fn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] true_count
);

    localparam logic [1:0] FN_LTU = 2'b00;
    localparam logic [1:0] FN_EQ  = 2'b01;
    localparam logic [1:0] FN_LT  = 2'b10;
    localparam logic [1:0] FN_LE  = 2'b11;

    logic en;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_s;
    logic             s1_c;
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [1:0]       s1_fn;

    logic [WIDTH:0]   diff;
    logic             s1_z;
    logic             s1_n;
    logic             s1_v;
    logic             cmp_bit;

    // Whole pipe advances together; a full S2 blocks only when the consumer stalls.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // a - b as a + ~b + 1, keeping the carry out in the top bit.
    assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_c     <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_fn    <= 2'b00;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_s     <= diff[WIDTH-1:0];
            s1_c     <= diff[WIDTH];
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b[WIDTH-1];
            s1_fn    <= cmp_fn;
        end
    end

    assign s1_z = (s1_s == '0);
    assign s1_n = s1_s[WIDTH-1];
    assign s1_v = (s1_a_msb & ~s1_b_msb & ~s1_n) | (~s1_a_msb & s1_b_msb & s1_n);

    always_comb begin
        cmp_bit = 1'b0;
        case (s1_fn)
            FN_LTU:  cmp_bit = ~s1_c;
            FN_EQ:   cmp_bit = s1_z;
            FN_LT:   cmp_bit = s1_n ^ s1_v;
            FN_LE:   cmp_bit = s1_z | (s1_n ^ s1_v);
            default: cmp_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 4'b0000;
        end else if (en) begin
            out_valid <= s1_valid;
            result    <= WIDTH'(cmp_bit);
            flags     <= {s1_z, s1_v, s1_n, s1_c};
        end
    end

    // Clear has priority over a same-cycle increment; count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            true_count <= '0;
        end else if (cnt_clr) begin
            true_count <= '0;
        end else if (out_valid && out_ready && result[0] && (true_count != '1)) begin
            true_count <= true_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe (WIDTH=3, COUNT_W=8).
module tb_cmp_pipe;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned COUNT_W = 8;

    localparam logic [1:0] LTU = 2'b00;
    localparam logic [1:0] EQ  = 2'b01;
    localparam logic [1:0] LT  = 2'b10;
    localparam logic [1:0] LE  = 2'b11;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [1:0]         cmp_fn;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [3:0]         flags;
    logic               cnt_clr;
    logic [COUNT_W-1:0] true_count;

    int tests = 0;
    int fails = 0;

    // Backpressure vectors and their expected results/flags {z,v,n,c}
    logic [WIDTH-1:0] bp_a   [4];
    logic [WIDTH-1:0] bp_b   [4];
    logic [1:0]       bp_fn  [4];
    logic [WIDTH-1:0] bp_res [4];
    logic [3:0]       bp_flg [4];
    int  sent;
    int  recv;
    int  delivered;
    bit  stalled;
    bit  fire_in;
    bit  seen_ov;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cmp_fn     (cmp_fn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .cnt_clr    (cnt_clr),
        .true_count (true_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe, checking 2-cycle latency and the output beat.
    task automatic beat(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [1:0] fn, input logic [WIDTH-1:0] er, input logic [3:0] ef);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cmp_fn = fn;
        step();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cmp_fn = EQ;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        step();
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    // Back-to-back a=2,b=3 LT (always true) for n cycles, counting deliveries.
    task automatic stream(input int n, output int dcount);
        dcount = 0;
        in_valid = 1'b1;
        a = 3'd2;
        b = 3'd3;
        cmp_fn = LT;
        for (int i = 0; i < n + 2; i++) begin
            if (i == n) in_valid = 1'b0;
            if (out_valid && out_ready) dcount++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        a = '0;
        b = '0;
        cmp_fn = LTU;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_cnt", 32'(true_count), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed compares: flags are {z,v,n,c}
        beat("eq_1_2",  3'd1, 3'd2, EQ,  3'b000, 4'b0010);
        beat("le_3_2",  3'd3, 3'd2, LE,  3'b000, 4'b0001);
        beat("lt_2_3",  3'd2, 3'd3, LT,  3'b001, 4'b0010);
        beat("lt_7_1",  3'd7, 3'd1, LT,  3'b001, 4'b0011);
        beat("ltu_7_1", 3'd7, 3'd1, LTU, 3'b000, 4'b0011);
        beat("lt_ovf",  3'd4, 3'd1, LT,  3'b001, 4'b0101);
        chk("cnt_directed", 32'(true_count), 32'd3);

        // Backpressure: out_ready low for the first 3 cycles
        bp_a[0] = 3'd2; bp_b[0] = 3'd3; bp_fn[0] = LT; bp_res[0] = 3'b001; bp_flg[0] = 4'b0010;
        bp_a[1] = 3'd3; bp_b[1] = 3'd2; bp_fn[1] = LE; bp_res[1] = 3'b000; bp_flg[1] = 4'b0001;
        bp_a[2] = 3'd4; bp_b[2] = 3'd1; bp_fn[2] = LT; bp_res[2] = 3'b001; bp_flg[2] = 4'b0101;
        bp_a[3] = 3'd1; bp_b[3] = 3'd1; bp_fn[3] = EQ; bp_res[3] = 3'b001; bp_flg[3] = 4'b1001;
        sent = 0;
        recv = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid = (sent < 4);
            if (sent < 4) begin
                a = bp_a[sent];
                b = bp_b[sent];
                cmp_fn = bp_fn[sent];
            end
            #1;
            if (!in_ready) stalled = 1'b1;
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_res%0d", recv), 32'(result), 32'(bp_res[recv]));
                chk($sformatf("bp_flags%0d", recv), 32'(flags), 32'(bp_flg[recv]));
                recv++;
            end
            @(posedge clk);
            #1;
            if (fire_in) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_recv", 32'(recv), 32'd4);
        chk("bp_stall", 32'(stalled), 32'd1);
        chk("bp_cnt", 32'(true_count), 32'd6);

        // Clear coincident with a true delivery
        in_valid = 1'b1;
        a = 3'd2;
        b = 3'd3;
        cmp_fn = LT;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_pre_ov", 32'(out_valid), 32'd1);
        chk("clr_pre_res", 32'(result), 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(true_count), 32'd0);

        // Saturation: exactly reach all-ones, then stay there
        stream(255, delivered);
        chk("sat_delivered", 32'(delivered), 32'd255);
        chk("sat_reach", 32'(true_count), 32'd255);
        stream(5, delivered);
        chk("sat_delivered2", 32'(delivered), 32'd5);
        chk("sat_hold", 32'(true_count), 32'd255);

        // Reset mid-stream
        in_valid = 1'b1;
        a = 3'd2;
        b = 3'd3;
        cmp_fn = LT;
        step();
        step();
        step();
        chk("mrst_pre_ov", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_ov", 32'(out_valid), 32'd0);
        chk("mrst_cnt", 32'(true_count), 32'd0);
        chk("mrst_res", 32'(result), 32'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("mrst_empty", 32'(seen_ov), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
